despachador_demux: RTL



---
 rtl/despachador_demux.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/despachador_demux.sv
// rtl/despachador_demux.sv - FIFO-buffered feeder driving X/Selector of a 1-to-4 demultiplexer

// Small word queue: head is visible combinationally, flush clears pointers and occupancy.
module despachador_fifo #(
  parameter int ANCHO = 4,
  parameter int PROF  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vaciar,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ANCHO-1:0]       dato,
  output logic [ANCHO-1:0]       cabeza,
  output logic                   lleno,
  output logic [$clog2(PROF):0]  cuenta
);

  localparam int AW = $clog2(PROF);
  localparam logic [AW:0] PROF_C = (AW+1)'(PROF);

  logic [ANCHO-1:0] mem [PROF];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign cabeza = mem[rd_ptr];
  assign lleno  = (cuenta == PROF_C);

  // Storage array: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dato;
    end
  end

  // Pointers wrap naturally because PROF is a power of two; push+pop leaves occupancy alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cuenta <= '0;
    end else if (vaciar) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cuenta <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cuenta <= cuenta + 1'b1;
        2'b01:   cuenta <= cuenta - 1'b1;
        default: cuenta <= cuenta;
      endcase
    end
  end

endmodule

// Dispatcher: pops one word at a time and presents it on X/Selector for HOLD cycles.
module despachador_demux #(
  parameter int ANCHO    = 4,
  parameter int PROF     = 4,
  parameter int HOLD     = 2,
  parameter int HUECO_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ANCHO-1:0]       dato_in,
  input  logic                   valido_in,
  output logic                   listo_out,
  input  logic                   modo,
  input  logic [1:0]             canal_fijo,
  input  logic                   vaciar,
  output logic [ANCHO-1:0]       X,
  output logic [2:0]             Selector,
  output logic                   ocupado,
  output logic [$clog2(PROF):0]  cuenta
);

  localparam logic [1:0] REPOSO = 2'd0;
  localparam logic [1:0] EMITIR = 2'd1;
  localparam logic [1:0] HUECO  = 2'd2;

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] CARGA_CONT = CW'(HOLD - 1);

  logic [1:0]       estado;
  logic [CW-1:0]    contador;
  logic [1:0]       rr;
  logic             lleno;
  logic             vacio;
  logic             push;
  logic             carga;
  logic [ANCHO-1:0] cabeza;
  logic [1:0]       canal;
  logic [2:0]       codigo;

  // A full queue never accepts, even if a word leaves in the same cycle.
  assign listo_out = !lleno && !vaciar;
  assign push      = valido_in && listo_out;
  assign vacio     = (cuenta == '0);
  assign ocupado   = (estado == EMITIR);

  // Channel choice and its select code; 000 is reserved for idle.
  assign canal  = modo ? rr : canal_fijo;
  assign codigo = {1'b0, canal} + 3'd1;

  despachador_fifo #(
    .ANCHO (ANCHO),
    .PROF  (PROF)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .vaciar (vaciar),
    .push   (push),
    .pop    (carga),
    .dato   (dato_in),
    .cabeza (cabeza),
    .lleno  (lleno),
    .cuenta (cuenta)
  );

  // Decide whether the head word is loaded this cycle (also the FIFO pop).
  always_comb begin
    carga = 1'b0;
    if (!vaciar && !vacio) begin
      case (estado)
        REPOSO:  carga = 1'b1;
        HUECO:   carga = 1'b1;
        EMITIR:  carga = (contador == '0) && (HUECO_EN == 0);
        default: carga = 1'b0;
      endcase
    end
  end

  // Round-robin pointer advances only on loads made in round-robin mode; flush keeps it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 2'd0;
    end else if (carga && modo) begin
      rr <= rr + 2'd1;
    end
  end

  // Output state machine: load, hold for HOLD cycles, optional idle guard, flush wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= REPOSO;
      X        <= '0;
      Selector <= 3'b000;
      contador <= '0;
    end else if (vaciar) begin
      estado   <= REPOSO;
      X        <= '0;
      Selector <= 3'b000;
      contador <= '0;
    end else if (carga) begin
      estado   <= EMITIR;
      X        <= cabeza;
      Selector <= codigo;
      contador <= CARGA_CONT;
    end else begin
      case (estado)
        EMITIR: begin
          if (contador != '0) begin
            contador <= contador - 1'b1;
          end else begin
            X        <= '0;
            Selector <= 3'b000;
            estado   <= (HUECO_EN != 0) ? HUECO : REPOSO;
          end
        end
        HUECO: begin
          estado <= REPOSO;
        end
        REPOSO: begin
          estado <= REPOSO;
        end
        default: begin
          estado   <= REPOSO;
          X        <= '0;
          Selector <= 3'b000;
          contador <= '0;
        end
      endcase
    end
  end

endmodule
